// File: rtl/alu_issue_queue_if.sv
// Dispatch / CDB / ALU-bank bundle for the ALU issue queue.
// The queue takes the slave view; dispatch and the ALU bank take the master view.
interface alu_issue_queue_if #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [3:0]        alloc_optype;
  logic [PREG_W-1:0] alloc_src1_preg;
  logic              alloc_src1_rdy;
  logic [31:0]       alloc_src1_data;
  logic [PREG_W-1:0] alloc_src2_preg;
  logic              alloc_src2_rdy;
  logic [31:0]       alloc_src2_data;
  logic [31:0]       alloc_imm;
  logic [PREG_W-1:0] alloc_dest_preg;
  logic [ROB_W-1:0]  alloc_rob_idx;
  logic              cdb_valid;
  logic [PREG_W-1:0] cdb_preg;
  logic [31:0]       cdb_data;
  logic [2:0]        fu_busy;
  logic [1:0]        issue_alu_number;
  logic [3:0]        issue_optype;
  logic [31:0]       issue_sr1;
  logic [31:0]       issue_sr2;
  logic [31:0]       issue_imm;
  logic [PREG_W-1:0] issue_dest_preg;
  logic [ROB_W-1:0]  issue_rob_idx;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  flush, alloc_valid, alloc_optype,
           alloc_src1_preg, alloc_src1_rdy, alloc_src1_data,
           alloc_src2_preg, alloc_src2_rdy, alloc_src2_data,
           alloc_imm, alloc_dest_preg, alloc_rob_idx,
           cdb_valid, cdb_preg, cdb_data, fu_busy,
    output alloc_ready, issue_alu_number, issue_optype, issue_sr1, issue_sr2,
           issue_imm, issue_dest_preg, issue_rob_idx, count
  );

  modport master (
    output flush, alloc_valid, alloc_optype,
           alloc_src1_preg, alloc_src1_rdy, alloc_src1_data,
           alloc_src2_preg, alloc_src2_rdy, alloc_src2_data,
           alloc_imm, alloc_dest_preg, alloc_rob_idx,
           cdb_valid, cdb_preg, cdb_data, fu_busy,
    input  alloc_ready, issue_alu_number, issue_optype, issue_sr1, issue_sr2,
           issue_imm, issue_dest_preg, issue_rob_idx, count
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Collapsing ALU issue queue: entry 0 is always the oldest, the oldest ready
// entry with a free ALU issues, younger entries shift down at the issue edge.
module alu_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  alu_issue_queue_if.slave io_q
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0]  r_count;
  logic [3:0]        r_op      [DEPTH];
  logic [PREG_W-1:0] r_s1_tag  [DEPTH];
  logic              r_s1_rdy  [DEPTH];
  logic [31:0]       r_s1_data [DEPTH];
  logic [PREG_W-1:0] r_s2_tag  [DEPTH];
  logic              r_s2_rdy  [DEPTH];
  logic [31:0]       r_s2_data [DEPTH];
  logic [31:0]       r_imm     [DEPTH];
  logic [PREG_W-1:0] r_dest    [DEPTH];
  logic [ROB_W-1:0]  r_rob     [DEPTH];

  logic [3:0]        w_n_op      [DEPTH];
  logic [PREG_W-1:0] w_n_s1_tag  [DEPTH];
  logic              w_n_s1_rdy  [DEPTH];
  logic [31:0]       w_n_s1_data [DEPTH];
  logic [PREG_W-1:0] w_n_s2_tag  [DEPTH];
  logic              w_n_s2_rdy  [DEPTH];
  logic [31:0]       w_n_s2_data [DEPTH];
  logic [31:0]       w_n_imm     [DEPTH];
  logic [PREG_W-1:0] w_n_dest    [DEPTH];
  logic [ROB_W-1:0]  w_n_rob     [DEPTH];

  logic [1:0]        r_iss_alu;
  logic [3:0]        r_iss_op;
  logic [31:0]       r_iss_sr1;
  logic [31:0]       r_iss_sr2;
  logic [31:0]       r_iss_imm;
  logic [PREG_W-1:0] r_iss_dest;
  logic [ROB_W-1:0]  r_iss_rob;

  logic              w_alloc_ready;
  logic              w_accept;
  logic              w_use1;
  logic              w_use2;
  logic [32:0]       w_a_s1;
  logic [32:0]       w_a_s2;
  logic              w_issue;
  logic [IDX_W-1:0]  w_sel;
  logic [1:0]        w_alu;
  logic [CNT_W-1:0]  w_wr_idx;
  logic [CNT_W-1:0]  w_n_count;

  // Resolve an allocating source to {rdy, value}: unused or tag 0 reads as
  // ready zero, and a same-cycle CDB hit is captured so it is not lost.
  function automatic logic [32:0] alloc_src(input logic use_src,
                                            input logic [PREG_W-1:0] tag,
                                            input logic rdy,
                                            input logic [31:0] data,
                                            input logic cdb_v,
                                            input logic [PREG_W-1:0] cdb_tag,
                                            input logic [31:0] cdb_d);
    if (!use_src || tag == '0) return {1'b1, 32'd0};
    if (rdy)                   return {1'b1, data};
    if (cdb_v && cdb_tag == tag) return {1'b1, cdb_d};
    return {1'b0, 32'd0};
  endfunction

  assign w_alloc_ready = (r_count < CNT_W'(DEPTH));
  assign w_accept = io_q.alloc_valid && w_alloc_ready && !io_q.flush &&
                    io_q.alloc_optype != 4'd0 && io_q.alloc_optype <= 4'd10;
  // LUI reads no register; ADD, XOR and the stores read both.
  assign w_use1 = (io_q.alloc_optype != 4'd3);
  assign w_use2 = (io_q.alloc_optype == 4'd1) || (io_q.alloc_optype == 4'd5) ||
                  (io_q.alloc_optype == 4'd9) || (io_q.alloc_optype == 4'd10);
  assign w_a_s1 = alloc_src(w_use1, io_q.alloc_src1_preg, io_q.alloc_src1_rdy,
                            io_q.alloc_src1_data, io_q.cdb_valid, io_q.cdb_preg, io_q.cdb_data);
  assign w_a_s2 = alloc_src(w_use2, io_q.alloc_src2_preg, io_q.alloc_src2_rdy,
                            io_q.alloc_src2_data, io_q.cdb_valid, io_q.cdb_preg, io_q.cdb_data);

  // Select the lowest-index ready entry that has an eligible ALU; memory ops use ALU 3 only.
  always_comb begin
    w_issue = 1'b0;
    w_sel   = '0;
    w_alu   = 2'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_issue && i < int'(r_count) && r_s1_rdy[i] && r_s2_rdy[i]) begin
        if (r_op[i] >= 4'd7) begin
          if (!io_q.fu_busy[2]) begin
            w_issue = 1'b1;
            w_sel   = IDX_W'(i);
            w_alu   = 2'd3;
          end
        end else if (io_q.fu_busy != 3'b111) begin
          w_issue = 1'b1;
          w_sel   = IDX_W'(i);
          w_alu   = !io_q.fu_busy[0] ? 2'd1 : (!io_q.fu_busy[1] ? 2'd2 : 2'd3);
        end
      end
    end
  end

  // Next entry state: collapse above the issued slot, apply CDB wakeup, then append the allocation.
  always_comb begin
    logic [IDX_W-1:0] j;
    j = '0;
    for (int i = 0; i < DEPTH; i++) begin
      j = (w_issue && i >= int'(w_sel) && i < DEPTH - 1) ? IDX_W'(i + 1) : IDX_W'(i);
      w_n_op[i]      = r_op[j];
      w_n_s1_tag[i]  = r_s1_tag[j];
      w_n_s1_rdy[i]  = r_s1_rdy[j];
      w_n_s1_data[i] = r_s1_data[j];
      w_n_s2_tag[i]  = r_s2_tag[j];
      w_n_s2_rdy[i]  = r_s2_rdy[j];
      w_n_s2_data[i] = r_s2_data[j];
      w_n_imm[i]     = r_imm[j];
      w_n_dest[i]    = r_dest[j];
      w_n_rob[i]     = r_rob[j];
      if (io_q.cdb_valid && !w_n_s1_rdy[i] && w_n_s1_tag[i] == io_q.cdb_preg) begin
        w_n_s1_rdy[i]  = 1'b1;
        w_n_s1_data[i] = io_q.cdb_data;
      end
      if (io_q.cdb_valid && !w_n_s2_rdy[i] && w_n_s2_tag[i] == io_q.cdb_preg) begin
        w_n_s2_rdy[i]  = 1'b1;
        w_n_s2_data[i] = io_q.cdb_data;
      end
    end
    w_wr_idx = w_issue ? r_count - CNT_W'(1) : r_count;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_accept && i == int'(w_wr_idx)) begin
        w_n_op[i]      = io_q.alloc_optype;
        w_n_s1_tag[i]  = io_q.alloc_src1_preg;
        w_n_s1_rdy[i]  = w_a_s1[32];
        w_n_s1_data[i] = w_a_s1[31:0];
        w_n_s2_tag[i]  = io_q.alloc_src2_preg;
        w_n_s2_rdy[i]  = w_a_s2[32];
        w_n_s2_data[i] = w_a_s2[31:0];
        w_n_imm[i]     = io_q.alloc_imm;
        w_n_dest[i]    = io_q.alloc_dest_preg;
        w_n_rob[i]     = io_q.alloc_rob_idx;
      end
    end
    w_n_count = r_count + CNT_W'(w_accept) - CNT_W'(w_issue);
  end

  // Entry storage; validity is carried by r_count alone, so no reset is needed here.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      r_op[i]      <= w_n_op[i];
      r_s1_tag[i]  <= w_n_s1_tag[i];
      r_s1_rdy[i]  <= w_n_s1_rdy[i];
      r_s1_data[i] <= w_n_s1_data[i];
      r_s2_tag[i]  <= w_n_s2_tag[i];
      r_s2_rdy[i]  <= w_n_s2_rdy[i];
      r_s2_data[i] <= w_n_s2_data[i];
      r_imm[i]     <= w_n_imm[i];
      r_dest[i]    <= w_n_dest[i];
      r_rob[i]     <= w_n_rob[i];
    end
  end

  // Occupancy and registered issue port; flush empties the queue and suppresses issue.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_count    <= '0;
      r_iss_alu  <= 2'd0;
      r_iss_op   <= 4'd0;
      r_iss_sr1  <= 32'd0;
      r_iss_sr2  <= 32'd0;
      r_iss_imm  <= 32'd0;
      r_iss_dest <= '0;
      r_iss_rob  <= '0;
    end else if (io_q.flush) begin
      r_count   <= '0;
      r_iss_alu <= 2'd0;
    end else begin
      r_count <= w_n_count;
      if (w_issue) begin
        r_iss_alu  <= w_alu;
        r_iss_op   <= r_op[w_sel];
        r_iss_sr1  <= r_s1_data[w_sel];
        r_iss_sr2  <= r_s2_data[w_sel];
        r_iss_imm  <= r_imm[w_sel];
        r_iss_dest <= r_dest[w_sel];
        r_iss_rob  <= r_rob[w_sel];
      end else begin
        r_iss_alu <= 2'd0;
      end
    end
  end

  assign io_q.alloc_ready      = w_alloc_ready;
  assign io_q.count            = r_count;
  assign io_q.issue_alu_number = r_iss_alu;
  assign io_q.issue_optype     = r_iss_op;
  assign io_q.issue_sr1        = r_iss_sr1;
  assign io_q.issue_sr2        = r_iss_sr2;
  assign io_q.issue_imm        = r_iss_imm;
  assign io_q.issue_dest_preg  = r_iss_dest;
  assign io_q.issue_rob_idx    = r_iss_rob;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: stimulus pushes expected issues into a
// scoreboard, a negedge monitor pops and compares each issue the DUT presents.
module tb_alu_issue_queue;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  typedef struct packed {
    logic [1:0]  alu;
    logic [3:0]  op;
    logic [31:0] sr1;
    logic [31:0] sr2;
    logic [31:0] imm;
    logic [5:0]  dest;
    logic [3:0]  rob;
  } exp_t;

  exp_t sb[$];

  alu_issue_queue_if q ();

  alu_issue_queue dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .io_q   (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [3:0] op, input logic [5:0] t1, input logic r1,
                       input logic [31:0] d1, input logic [5:0] t2, input logic r2,
                       input logic [31:0] d2, input logic [31:0] imm,
                       input logic [5:0] dest, input logic [3:0] rob);
    q.alloc_valid     = 1'b1;
    q.alloc_optype    = op;
    q.alloc_src1_preg = t1;
    q.alloc_src1_rdy  = r1;
    q.alloc_src1_data = d1;
    q.alloc_src2_preg = t2;
    q.alloc_src2_rdy  = r2;
    q.alloc_src2_data = d2;
    q.alloc_imm       = imm;
    q.alloc_dest_preg = dest;
    q.alloc_rob_idx   = rob;
    tick();
    q.alloc_valid = 1'b0;
  endtask

  task automatic push(input logic [1:0] alu, input logic [3:0] op, input logic [31:0] sr1,
                      input logic [31:0] sr2, input logic [31:0] imm,
                      input logic [5:0] dest, input logic [3:0] rob);
    exp_t e;
    e.alu = alu; e.op = op; e.sr1 = sr1; e.sr2 = sr2;
    e.imm = imm; e.dest = dest; e.rob = rob;
    sb.push_back(e);
  endtask

  // Monitor: every issue the DUT presents must match the oldest expected issue.
  always @(negedge clk) begin
    if (rstn && q.issue_alu_number != 2'd0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_issue actual alu=%0d dest=%0d required no issue at %0t",
                 q.issue_alu_number, q.issue_dest_preg, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("iss_alu",  32'(q.issue_alu_number), 32'(e.alu));
        chk("iss_op",   32'(q.issue_optype),     32'(e.op));
        chk("iss_sr1",  q.issue_sr1,             e.sr1);
        chk("iss_sr2",  q.issue_sr2,             e.sr2);
        chk("iss_imm",  q.issue_imm,             e.imm);
        chk("iss_dest", 32'(q.issue_dest_preg),  32'(e.dest));
        chk("iss_rob",  32'(q.issue_rob_idx),    32'(e.rob));
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn = 1'b0;
    q.flush = 1'b0;
    q.alloc_valid = 1'b0;
    q.alloc_optype = 4'd1;
    q.alloc_src1_preg = 6'd1; q.alloc_src1_rdy = 1'b1; q.alloc_src1_data = 32'd9;
    q.alloc_src2_preg = 6'd2; q.alloc_src2_rdy = 1'b1; q.alloc_src2_data = 32'd9;
    q.alloc_imm = 32'd0; q.alloc_dest_preg = 6'd1; q.alloc_rob_idx = 4'd0;
    q.cdb_valid = 1'b0; q.cdb_preg = 6'd0; q.cdb_data = 32'd0;
    q.fu_busy = 3'b000;

    // Reset held two cycles while dispatch presents a valid op.
    q.alloc_valid = 1'b1;
    tick();
    tick();
    rstn = 1'b1;
    q.alloc_valid = 1'b0;
    chk("rst_alloc_ready", 32'(q.alloc_ready), 32'd1);
    chk("rst_count", 32'(q.count), 32'd0);
    chk("rst_alu", 32'(q.issue_alu_number), 32'd0);
    tick();
    chk("rst_idle_alu", 32'(q.issue_alu_number), 32'd0);

    // Illegal optypes are dropped.
    alloc(4'd0, 6'd3, 1'b1, 32'd1, 6'd4, 1'b1, 32'd1, 32'd0, 6'd9, 4'd9);
    alloc(4'd11, 6'd3, 1'b1, 32'd1, 6'd4, 1'b1, 32'd1, 32'd0, 6'd9, 4'd9);
    chk("drop_count", 32'(q.count), 32'd0);
    tick();
    chk("drop_no_issue", 32'(q.issue_alu_number), 32'd0);

    // Ready ADD issues to ALU 1 two edges after allocation.
    push(2'd1, 4'd1, 32'd5, 32'd7, 32'h11, 6'd10, 4'd1);
    alloc(4'd1, 6'd3, 1'b1, 32'd5, 6'd4, 1'b1, 32'd7, 32'h11, 6'd10, 4'd1);
    chk("add_count", 32'(q.count), 32'd1);
    tick();
    chk("add_latency_alu", 32'(q.issue_alu_number), 32'd1);
    tick();

    // Same-cycle CDB bypass on an ADDI source.
    q.cdb_valid = 1'b1; q.cdb_preg = 6'd12; q.cdb_data = 32'h40;
    push(2'd1, 4'd2, 32'h40, 32'd0, 32'd5, 6'd11, 4'd2);
    alloc(4'd2, 6'd12, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 32'd5, 6'd11, 4'd2);
    q.cdb_valid = 1'b0;
    tick();
    chk("bypass_no_stall", 32'(q.issue_alu_number), 32'd1);
    tick();

    // XOR with ALU 1 busy goes to ALU 2; tag-0 source reads zero despite data.
    q.fu_busy = 3'b001;
    push(2'd2, 4'd5, 32'hF0, 32'd0, 32'd0, 6'd13, 4'd3);
    alloc(4'd5, 6'd7, 1'b1, 32'hF0, 6'd0, 1'b0, 32'hDEAD, 32'd0, 6'd13, 4'd3);
    tick();
    chk("xor_alu2", 32'(q.issue_alu_number), 32'd2);
    q.fu_busy = 3'b000;
    tick();

    // LW waits while ALU 3 is busy, then goes to ALU 3.
    q.fu_busy = 3'b100;
    alloc(4'd8, 6'd5, 1'b1, 32'h100, 6'd0, 1'b0, 32'd0, 32'd4, 6'd14, 4'd4);
    tick();
    tick();
    chk("lw_blocked_alu", 32'(q.issue_alu_number), 32'd0);
    chk("lw_blocked_count", 32'(q.count), 32'd1);
    q.fu_busy = 3'b000;
    push(2'd3, 4'd8, 32'h100, 32'd0, 32'd4, 6'd14, 4'd4);
    tick();
    chk("lw_alu3", 32'(q.issue_alu_number), 32'd3);
    tick();
    chk("lw_empty", 32'(q.count), 32'd0);

    // Fill with unready entries; entries 2 and 5 share tag 30.
    for (int i = 0; i < 8; i++) begin
      alloc(4'd1, (i == 2 || i == 5) ? 6'd30 : 6'(20 + i), 1'b0, 32'd0,
            6'd0, 1'b0, 32'd0, 32'(256 + i), 6'(i + 1), 4'(i));
    end
    chk("full_count", 32'(q.count), 32'd8);
    chk("full_ready", 32'(q.alloc_ready), 32'd0);
    q.cdb_valid = 1'b1; q.cdb_preg = 6'd30; q.cdb_data = 32'h55;
    q.alloc_valid = 1'b1; q.alloc_optype = 4'd1;
    q.alloc_src1_preg = 6'd0; q.alloc_src2_preg = 6'd0;
    q.alloc_dest_preg = 6'd63; q.alloc_rob_idx = 4'd15;
    push(2'd1, 4'd1, 32'h55, 32'd0, 32'd258, 6'd3, 4'd2);
    push(2'd1, 4'd1, 32'h55, 32'd0, 32'd261, 6'd6, 4'd5);
    tick();
    q.cdb_valid = 1'b0;
    chk("full_issue_cycle_ready", 32'(q.alloc_ready), 32'd0);
    chk("full_issue_cycle_count", 32'(q.count), 32'd8);
    tick();
    q.alloc_valid = 1'b0;
    chk("full_refused_count", 32'(q.count), 32'd7);
    tick();
    chk("after_two_issues_count", 32'(q.count), 32'd6);

    // Clear the leftovers, then flush with four entries and a concurrent alloc.
    q.flush = 1'b1;
    tick();
    q.flush = 1'b0;
    chk("flush1_count", 32'(q.count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      alloc(4'd1, 6'(40 + i), 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 32'd0, 6'(i + 20), 4'(i));
    end
    chk("pre_flush_count", 32'(q.count), 32'd4);
    q.flush = 1'b1;
    q.alloc_valid = 1'b1; q.alloc_optype = 4'd1;
    q.alloc_src1_preg = 6'd0; q.alloc_src2_preg = 6'd0;
    tick();
    q.flush = 1'b0;
    q.alloc_valid = 1'b0;
    chk("flush_count", 32'(q.count), 32'd0);
    chk("flush_alu", 32'(q.issue_alu_number), 32'd0);
    for (int i = 0; i < 4; i++) begin
      q.cdb_valid = 1'b1; q.cdb_preg = 6'(40 + i); q.cdb_data = 32'(i + 1);
      tick();
    end
    q.cdb_valid = 1'b0;
    tick();
    tick();
    chk("post_flush_alu", 32'(q.issue_alu_number), 32'd0);
    chk("post_flush_count", 32'(q.count), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
